// File: rtl/lsu_dmem_master.sv
// Load/store master for a word-wide data memory.
// Sub-word stores go through read-modify-write; bad requests respond without memory access.
module lsu_dmem_master #(
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic        clk_i,
    input  logic        reset_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        Memread_o,
    output logic        Memwrite_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_e;

    state_e      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] base_q, base_d;

    logic [31:0] req_base;
    logic        req_illegal;
    logic        req_misalign;
    logic        req_range;
    logic        req_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    always_comb begin
        req_base = {req_addr_i[31:2], 2'b00};
        req_range = ({1'b0, req_base} + 33'd4) > 33'(MEM_BYTES);
        if (req_we_i) begin
            req_illegal = !(req_funct3_i inside {3'b000, 3'b001, 3'b010});
        end else begin
            req_illegal = !(req_funct3_i inside
                            {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        req_misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                       ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        req_err = req_illegal || req_misalign || req_range;
    end

    // Lane extraction for loads, lane insertion for sub-word stores.
    always_comb begin
        ld_byte = mem_rdata_i[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        unique case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata_i;
        endcase
        merged = merge_q;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        base_d   = base_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    lane_d   = req_addr_i[1:0];
                    funct3_d = req_funct3_i;
                    wdata_d  = req_wdata_i;
                    rdata_d  = 32'h0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        base_d = req_base;
                        if (!req_we_i) begin
                            state_d = LOAD;
                        end else if (req_funct3_i == 3'b010) begin
                            state_d = WRITE;
                        end else begin
                            state_d = RMW_RD;
                        end
                    end
                end
            end
            LOAD: begin
                rdata_d = ld_ext;
                state_d = RESP;
            end
            RMW_RD: begin
                merge_d = mem_rdata_i;
                state_d = WRITE;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            lane_q   <= 2'b00;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            base_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            base_q   <= base_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_err_o   = (state_q == RESP) && err_q;
    assign rsp_rdata_o = rdata_q;
    assign Memread_o   = (state_q == LOAD) || (state_q == RMW_RD);
    assign Memwrite_o  = (state_q == WRITE);
    assign mem_addr_o  = base_q;
    assign mem_wdata_o = (state_q != WRITE) ? 32'h0 :
                         (funct3_q == 3'b010) ? wdata_q : merged;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master with a small behavioural memory.
// Expected values are hand-computed from the preloaded words.
module tb_lsu_dmem_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'b000;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        Memread_o;
    logic        Memwrite_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] mem [8];
    int total = 0;
    int bad = 0;

    lsu_dmem_master #(.MEM_BYTES(32)) dut (
        .clk_i(clk), .reset_n(reset_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .Memread_o(Memread_o),
        .Memwrite_o(Memwrite_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    assign mem_rdata_i = mem[mem_addr_o[4:2]];

    always @(posedge clk) begin
        if (Memwrite_o) mem[mem_addr_o[4:2]] <= mem_wdata_o;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, then watch until the response or a cycle budget.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd,
                          output logic err, output int nrd, output int nwr,
                          output logic [31:0] wword);
        lat = 0; rd = '0; err = 1'b0; nrd = 0; nwr = 0; wword = '0;
        @(negedge clk);
        chk("ready_idle", {31'h0, req_ready_o}, 32'h1);
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
        req_addr_i = addr; req_wdata_i = wd;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (Memread_o) nrd++;
            if (Memwrite_o) begin
                nwr++;
                wword = mem_wdata_o;
            end
            if (rsp_valid_o) begin
                lat = c; rd = rsp_rdata_o; err = rsp_err_o;
                break;
            end
        end
        if (lat == 0) chk("rsp_timeout", 32'h0, 32'h1);
    endtask

    task automatic t_load(input string tag, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] exp);
        int lat, nrd, nwr;
        logic [31:0] rd, ww;
        logic err;
        do_req(1'b0, f3, addr, 32'h0, lat, rd, err, nrd, nwr, ww);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_err"}, {31'h0, err}, 32'h0);
        chk({tag, "_nrd"}, nrd, 1);
    endtask

    task automatic t_err(input string tag, input logic we,
                         input logic [2:0] f3, input logic [31:0] addr);
        int lat, nrd, nwr;
        logic [31:0] rd, ww;
        logic err;
        do_req(we, f3, addr, 32'hFFFF_FFFF, lat, rd, err, nrd, nwr, ww);
        chk({tag, "_err"}, {31'h0, err}, 32'h1);
        chk({tag, "_data"}, rd, 32'h0);
        chk({tag, "_lat"}, lat, 1);
        chk({tag, "_strobes"}, nrd + nwr, 0);
    endtask

    task automatic t_store(input string tag, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_word, input int exp_lat,
                           input int exp_rd);
        int lat, nrd, nwr;
        logic [31:0] rd, ww;
        logic err;
        do_req(1'b1, f3, addr, wd, lat, rd, err, nrd, nwr, ww);
        chk({tag, "_word"}, ww, exp_word);
        chk({tag, "_nwr"}, nwr, 1);
        chk({tag, "_nrd"}, nrd, exp_rd);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_err"}, {31'h0, err}, 32'h0);
        chk({tag, "_data"}, rd, 32'h0);
        chk({tag, "_mem"}, mem[addr[4:2]], exp_word);
    endtask

    initial begin
        mem[0] = 32'h80F1_7F01;
        mem[1] = 32'h1122_3344;
        mem[2] = 32'h0;
        mem[3] = 32'h0;
        mem[4] = 32'h0;
        mem[5] = 32'h0;
        mem[6] = 32'h0;
        mem[7] = 32'h7654_3210;

        #12;
        chk("rst_ready", {31'h0, req_ready_o}, 32'h1);
        chk("rst_rsp", {29'h0, rsp_valid_o, rsp_err_o, Memread_o}, 32'h0);
        chk("rst_wr", {31'h0, Memwrite_o}, 32'h0);
        chk("rst_rdata", rsp_rdata_o, 32'h0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_wdata", mem_wdata_o, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        t_load("lb3", 3'b000, 32'd3, 32'hFFFF_FF80);
        t_load("lbu3", 3'b100, 32'd3, 32'h0000_0080);
        t_load("lb1", 3'b000, 32'd1, 32'h0000_007F);
        t_load("lh2", 3'b001, 32'd2, 32'hFFFF_80F1);
        t_load("lhu0", 3'b101, 32'd0, 32'h0000_7F01);
        t_load("lw0", 3'b010, 32'd0, 32'h80F1_7F01);
        chk("addr_hold", mem_addr_o, 32'h0);

        t_store("sb5", 3'b000, 32'd5, 32'h0000_00AB, 32'h1122_AB44, 3, 1);
        chk("addr_hold4", mem_addr_o, 32'h4);
        mem[1] = 32'h1122_3344;
        t_store("sh6", 3'b001, 32'd6, 32'hDEAD_BEEF, 32'hBEEF_3344, 3, 1);

        t_err("lw2", 1'b0, 3'b010, 32'd2);
        t_err("sh1", 1'b1, 3'b001, 32'd1);
        t_err("ldf3", 1'b0, 3'b011, 32'd0);
        t_err("stf4", 1'b1, 3'b100, 32'd0);
        t_load("lw28", 3'b010, 32'd28, 32'h7654_3210);
        t_err("lw32", 1'b0, 3'b010, 32'd32);
        chk("err_addr_hold", mem_addr_o, 32'd28);

        // SW then LW to address 8 with valid held high throughout.
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010;
        req_addr_i = 32'd8; req_wdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        chk("b2b_wr", {31'h0, Memwrite_o}, 32'h1);
        chk("b2b_rdy1", {31'h0, req_ready_o}, 32'h0);
        @(negedge clk);
        chk("b2b_rsp", {31'h0, rsp_valid_o}, 32'h1);
        chk("b2b_rdy2", {31'h0, req_ready_o}, 32'h0);
        req_we_i = 1'b0;
        @(negedge clk);
        chk("b2b_rdy3", {31'h0, req_ready_o}, 32'h1);
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("b2b_ld", {31'h0, Memread_o}, 32'h1);
        @(negedge clk);
        chk("b2b_lrsp", {31'h0, rsp_valid_o}, 32'h1);
        chk("b2b_ldata", rsp_rdata_o, 32'hCAFE_F00D);

        // Abort an SB in its WRITE cycle with reset.
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b000;
        req_addr_i = 32'd5; req_wdata_i = 32'h0000_0055;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ab_inwr", {31'h0, Memwrite_o}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("ab_wrdrop", {31'h0, Memwrite_o}, 32'h0);
        chk("ab_ready", {31'h0, req_ready_o}, 32'h1);
        chk("ab_rsp", {31'h0, rsp_valid_o}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ab_norsp", {31'h0, rsp_valid_o}, 32'h0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("ab_norsp2", {31'h0, rsp_valid_o}, 32'h0);
        chk("ab_mem", mem[1], 32'hBEEF_3344);
        t_load("ab_lw4", 3'b010, 32'd4, 32'hBEEF_3344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Load/store unit that initiates all accesses to the data memory on behalf of the execute stage.
- Takes one RV32I load or store request at a time over a valid/ready handshake.
- Always issues word-aligned, full-word read/write cycles to the memory.
- Implements LB/LH/LBU/LHU by lane extraction plus extension, and SB/SH by read-modify-write.
- Reports misaligned, out-of-range and illegal-funct3 accesses as errors without touching memory.

Parameters:
- MEM_BYTES, 32, size of the attached byte-addressed memory; must be a multiple of 4.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  high only in IDLE; handshake = valid & ready at a rising edge.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data; the low byte or halfword is used for SB/SH.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  32  extended load result; 0 for stores and errors.
- rsp_err_o  out  1  valid with rsp_valid_o.
- Memread_o  out  1  memory read strobe; memory read data is combinational in the same cycle.
- Memwrite_o  out  1  memory write strobe; memory writes on the rising edge.
- mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_wdata_o  out  32  write word.
- mem_rdata_i  in  32  read word, little-endian: byte at address A is bits [7:0].

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE; any in-flight operation is abandoned with no response.
  - Memread_o, Memwrite_o, rsp_valid_o and rsp_err_o drop to 0 immediately.
  - rsp_rdata_o, mem_addr_o, mem_wdata_o and all internal registers reset to 0.
  - req_ready_o = 1 because the state is IDLE. Requests are sampled only on clock edges with reset_n high.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- On handshake, address, funct3, we and wdata are registered. Next state:
  - error -> RESP with err = 1
  - load -> LOAD
  - SW -> WRITE
  - SB/SH -> RMW_RD
- Error conditions, any of:
  - illegal funct3 for the direction;
  - LH/LHU/SH with addr[0] = 1;
  - LW/SW with addr[1:0] != 0;
  - aligned base + 4 > MEM_BYTES.
- LOAD (1 cycle): Memread_o = 1. mem_rdata_i lane is selected by addr[1:0], sign- or zero-extended, and registered into rsp_rdata_o. Next state RESP.
- RMW_RD (1 cycle): Memread_o = 1. mem_rdata_i is registered into a merge buffer. Next state WRITE.
- WRITE (1 cycle): Memwrite_o = 1.
  - SW: mem_wdata_o = wdata.
  - SB: merge buffer with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: merge buffer with halfword addr[1] replaced by wdata[15:0].
  - Next state RESP.
- RESP (1 cycle): rsp_valid_o = 1; next state IDLE.
- Latency from handshake edge to rsp_valid_o: loads 2 cycles, SW 2, SB/SH 3, errors 1.
- Memread_o and Memwrite_o are never high together and are never high in IDLE or RESP.
- req_ready_o = 0 in every non-IDLE state, so there is at most one outstanding request.
- The response has no backpressure.
- mem_addr_o holds the last aligned base between accesses.

Test Plan:
- Memory preloaded 0x80F17F01 at address 0. LB addr 3 -> rdata 0xFFFFFF80, 2 cycles after handshake. LBU addr 3 -> 0x00000080. LH addr 2 -> 0xFFFF80F1. LW addr 0 -> 0x80F17F01.
- SB addr 5, wdata 0x000000AB, word at 4 = 0x11223344 -> RMW_RD then WRITE of 0x1122AB44, Memwrite_o high exactly one cycle, rsp_valid_o 3 cycles after handshake.
- SH addr 6, wdata 0xDEADBEEF, word at 4 = 0x11223344 -> write 0xBEEF3344.
- Error cases, each with rsp_err_o = 1, rdata 0, response 1 cycle after handshake, no Memread_o/Memwrite_o pulse:
  - LW addr 2;
  - SH addr 1;
  - load funct3 011;
  - LW addr 28 (allowed) vs LW addr 32 (error).
- Back-to-back req_valid_i held high with SW then LW at addr 8 -> ready low until RESP completes. LW returns the stored value.
- reset_n low during WRITE of an SB -> Memwrite_o drops immediately, no rsp_valid_o, ready = 1. After release, a new LW completes normally.
